// File: rtl/cmd_issuer.sv
// Key-event front end for the dungeon engine: decodes keys into command words,
// filters illegal/bouncing events and queues the survivors in a show-ahead FIFO.
module cmd_issuer #(
  parameter int DEPTH   = 8,
  parameter int HOLDOFF = 4,
  parameter int CW      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     key_valid,
  input  logic [7:0]               key_code,
  input  logic                     in_battle,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [CW-1:0]            cmd_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               drop_cnt,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic {READY, HOLD} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  last_cmd_q, last_cmd_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic [7:0]     drop_cnt_q, drop_cnt_d;
  logic           overflow_q, overflow_d;

  logic [CW-1:0]  mem [DEPTH];

  logic [CW-1:0]  dec_cmd;
  logic           legal;
  logic           bounce;
  logic           candidate;
  logic           full;
  logic           pop;
  logic           push;
  logic           full_drop;
  logic           drop;

  // Movement is only meaningful while exploring, attack/run only in battle.
  always_comb begin
    dec_cmd = '0;
    legal   = 1'b0;
    case (key_code)
      8'h64: begin dec_cmd = CW'(16'h0001); legal = !in_battle; end
      8'h61: begin dec_cmd = CW'(16'h0002); legal = !in_battle; end
      8'h77: begin dec_cmd = CW'(16'h0003); legal = !in_battle; end
      8'h73: begin dec_cmd = CW'(16'h0004); legal = !in_battle; end
      8'h66: begin dec_cmd = CW'(16'h0005); legal = in_battle;  end
      8'h72: begin dec_cmd = CW'(16'h0006); legal = in_battle;  end
      8'h68: begin dec_cmd = CW'(16'h0010); legal = 1'b1;       end
      default: begin dec_cmd = '0; legal = 1'b0; end
    endcase
  end

  always_comb begin
    full      = (level_q == LW'(DEPTH));
    pop       = (level_q != '0) && cmd_ready;
    bounce    = (state_q == HOLD) && (dec_cmd == last_cmd_q);
    candidate = key_valid && legal && !bounce;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    push      = candidate && (!full || pop);
    full_drop = candidate && !push;
    drop      = key_valid && !push;
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
    drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    overflow_d = overflow_q | full_drop;
  end

  always_comb begin
    state_d    = state_q;
    last_cmd_d = last_cmd_q;
    hold_d     = hold_q;
    case (state_q)
      READY: begin
        if (push) begin
          state_d    = HOLD;
          last_cmd_d = dec_cmd;
          hold_d     = HW'(HOLDOFF - 1);
        end
      end
      HOLD: begin
        if (push) begin
          last_cmd_d = dec_cmd;
          hold_d     = HW'(HOLDOFF - 1);
        end else if (hold_q != '0) begin
          hold_d = hold_q - HW'(1);
        end else if (!key_valid) begin
          state_d = READY;
        end
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= READY;
      last_cmd_q <= '0;
      hold_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_cmd_q <= last_cmd_d;
      hold_q     <= hold_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= dec_cmd;
    end
  end

  assign cmd_valid  = (level_q != '0);
  assign cmd_data   = cmd_valid ? mem[rd_ptr_q] : '0;
  assign fifo_level = level_q;
  assign drop_cnt   = drop_cnt_q;
  assign overflow   = overflow_q;

endmodule
